aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_round_counter.sv | 28 ++
 rtl/aes_round_sequencer.sv | 145 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer: state encoding,
// key-length codes and the round-count lookup.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_RSV = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Reserved code never reaches the datapath; it maps to the 128-bit count.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Loadable up/down round counter with a flag for reaching a supplied
// terminal value; load takes priority over counting.
module aes_round_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_at_term
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en)   r_count <= i_up ? r_count + W'(1) : r_count - W'(1);
  end

  assign o_count   = r_count;
  assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps the round index and datapath input mux for
// encrypt/decrypt at 128/192/256-bit keys. Optional abort via AES_SEQ_ABORT_EN.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               encrypt,
  input  logic [1:0]         key_len,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic [DATA_W-1:0]  round_key,
  input  logic [DATA_W-1:0]  enc_result,
  input  logic [DATA_W-1:0]  dec_result,
`ifdef AES_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic [ROUND_W-1:0] round,
  output logic [DATA_W-1:0]  data,
  output logic [DATA_W-1:0]  tx_data,
  output logic               ready,
  output logic               busy,
  output logic               last_round,
  output logic               load_enable,
  output logic               done,
  output logic               err
);

  state_e              r_state;
  logic                r_enc;
  logic [1:0]          r_klen;
  logic [DATA_W-1:0]   r_key;
  logic [DATA_W-1:0]   r_tx;
  logic                r_err;

  logic                w_abort;
  logic                w_accept;
  logic                w_load;
  logic [ROUND_W-1:0]  w_load_val;
  logic                w_en;
  logic [ROUND_W-1:0]  w_nr;
  logic [ROUND_W-1:0]  w_term;
  logic [ROUND_W-1:0]  w_count;
  logic                w_at_term;
  logic [DATA_W-1:0]   w_data;

`ifdef AES_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && start && !w_abort && (key_len != KL_RSV);
  assign w_nr     = ROUND_W'(nr_of(r_klen));
  assign w_term   = r_enc ? (w_nr - ROUND_W'(1)) : ROUND_W'(1);

  // Decrypt preloads Nr so PRELOAD and INIT both present the last round key.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_load     = 1'b1;
        w_load_val = encrypt ? '0 : ROUND_W'(nr_of(key_len));
      end
      S_INIT, S_ROUND: w_en   = 1'b1;
      S_FINAL:         w_load = 1'b1;
      default: ;
    endcase
    if (w_abort && r_state != S_IDLE) begin
      w_load     = 1'b1;
      w_load_val = '0;
      w_en       = 1'b0;
    end
  end

  aes_round_counter #(.W(ROUND_W)) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .i_up       (r_enc),
    .i_term     (w_term),
    .o_count    (w_count),
    .o_at_term  (w_at_term)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_key <= '0;
    else        r_key <= round_key;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_enc   <= 1'b0;
      r_klen  <= KL_128;
      r_tx    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (start && !w_abort) begin
          if (key_len == KL_RSV) r_err <= 1'b1;
          else begin
            r_enc   <= encrypt;
            r_klen  <= key_len;
            r_state <= encrypt ? S_INIT : S_PRELOAD;
          end
        end
        S_PRELOAD: r_state <= S_INIT;
        S_INIT:    r_state <= S_ROUND;
        S_ROUND:   if (w_at_term) r_state <= S_FINAL;
        S_FINAL:   r_state <= S_DONE;
        S_DONE: begin
          if (!w_abort) r_tx <= w_data;
          r_state <= S_IDLE;
        end
        default:   r_state <= S_IDLE;
      endcase
      if (w_abort && r_state != S_IDLE) r_state <= S_IDLE;
    end
  end

  always_comb begin
    w_data = r_enc ? enc_result : dec_result;
    if (r_state == S_INIT) w_data = rx_data ^ (r_enc ? round_key : r_key);
  end

  assign round       = w_count;
  assign data        = w_data;
  assign tx_data     = r_tx;
  assign ready       = (r_state == S_IDLE);
  assign busy        = !ready;
  assign last_round  = ready || (r_state == S_ROUND && w_at_term);
  assign done        = (r_state == S_DONE) && !w_abort;
  assign load_enable = done;
  assign err         = r_err;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: table-driven and random
// operations against a round-sequence model, plus reset/err/abort corners.
module tb_aes_round_sequencer;

  localparam int DW = 128;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start, encrypt;
  logic [1:0]    key_len;
  logic [DW-1:0] rx_data, round_key, enc_result, dec_result;
  logic [RW-1:0] round;
  logic [DW-1:0] data, tx_data;
  logic          ready, busy, last_round, load_enable, done, err;
`ifdef AES_SEQ_ABORT_EN
  logic          abort;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_tx_last = '0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.DATA_W(DW), .ROUND_W(RW)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .encrypt     (encrypt),
    .key_len     (key_len),
    .rx_data     (rx_data),
    .round_key   (round_key),
    .enc_result  (enc_result),
    .dec_result  (dec_result),
`ifdef AES_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .round       (round),
    .data        (data),
    .tx_data     (tx_data),
    .ready       (ready),
    .busy        (busy),
    .last_round  (last_round),
    .load_enable (load_enable),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    logic       enc;
    logic [1:0] kl;
    int         exp_lat;
    bit         glitch;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int nr_model(input logic [1:0] kl);
    return (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
  endfunction

  task automatic drive_rand();
    round_key  = rnd();
    enc_result = rnd();
    dec_result = rnd();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full operation, starting in an IDLE cycle; returns in the IDLE cycle after done.
  task automatic run_op(input logic enc, input logic [1:0] kl, input int exp_lat, input bit glitch);
    int nr, lat, idx, init_idx;
    int exp_r[$];
    logic [DW-1:0] rx, rk_prev, exp_tx, exp_d;
    nr = nr_model(kl);
    if (enc) begin
      for (int i = 0; i <= nr; i++) exp_r.push_back(i);
    end else begin
      exp_r.push_back(nr);
      for (int i = nr; i >= 0; i--) exp_r.push_back(i);
    end
    init_idx = enc ? 0 : 1;
    rx = rnd();
    exp_tx = '0;
    start = 1'b1; encrypt = enc; key_len = kl; rx_data = rx;
    drive_rand();
    #1;
    chk("ready_at_start", DW'(ready), DW'(1'b1));
    rk_prev = round_key;
    tick();
    lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start   = 1'b0;
      drive_rand();
      encrypt = 1'($urandom);
      key_len = 2'($urandom);
      idx = cyc - 1;
      if (glitch && idx < exp_r.size() && exp_r[idx] == 5) begin
        start = 1'b1; encrypt = !enc;
      end
      #1;
      if (done) begin
        lat = cyc;
        exp_tx = enc ? enc_result : dec_result;
        chk("load_enable", DW'(load_enable), DW'(1'b1));
        chk("done_round", DW'(round), '0);
        chk("done_busy", DW'(busy), DW'(1'b1));
        start = 1'b0;
        tick();
        break;
      end
      chk("busy", DW'(busy), DW'(1'b1));
      if (idx < exp_r.size()) begin
        chk("round", DW'(round), DW'(exp_r[idx]));
        chk("last_round", DW'(last_round), DW'(idx == exp_r.size() - 2));
        if (idx == init_idx) exp_d = rx ^ (enc ? round_key : rk_prev);
        else                 exp_d = enc ? enc_result : dec_result;
        chk("data", data, exp_d);
      end
      rk_prev = round_key;
      tick();
    end
    chk("latency", DW'(lat), DW'(exp_lat));
    #1;
    chk("tx_data", tx_data, exp_tx);
    chk("ready_after", DW'(ready), DW'(1'b1));
    chk("done_cleared", DW'(done), '0);
    exp_tx_last = exp_tx;
  endtask

  // Start an encrypt op and advance until the given round shows; bounded.
  task automatic run_to_round(input logic [1:0] kl, input int target);
    bit hit = 0;
    start = 1'b1; encrypt = 1'b1; key_len = kl; rx_data = rnd();
    drive_rand();
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive_rand();
      #1;
      if (round == RW'(target) && busy) begin hit = 1; break; end
      tick();
    end
    chk("reach_round", DW'(hit), DW'(1'b1));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_done"},  DW'(done), '0);
    chk({tag, "_load"},  DW'(load_enable), '0);
    chk({tag, "_err"},   DW'(err), '0);
    chk({tag, "_busy"},  DW'(busy), '0);
    chk({tag, "_ready"}, DW'(ready), DW'(1'b1));
    chk({tag, "_last"},  DW'(last_round), DW'(1'b1));
    chk({tag, "_round"}, DW'(round), '0);
    chk({tag, "_tx"},    tx_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, 2'd0, 12, 1'b0};
    vecs[1] = '{1'b0, 2'd2, 17, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 14, 1'b1};
    vecs[3] = '{1'b0, 2'd0, 13, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 16, 1'b0};
    vecs[5] = '{1'b0, 2'd1, 15, 1'b1};

    n_rst = 1'b0; start = 1'b0; encrypt = 1'b0; key_len = 2'd0;
    rx_data = '0; round_key = '0; enc_result = '0; dec_result = '0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk_reset_outs("rst");
    @(negedge clk); n_rst = 1'b1;
    tick();

    // Back-to-back: each op starts in the IDLE cycle right after the previous done.
    foreach (vecs[i]) run_op(vecs[i].enc, vecs[i].kl, vecs[i].exp_lat, vecs[i].glitch);

    for (int i = 0; i < 8; i++) begin
      logic e;
      logic [1:0] k;
      e = 1'($urandom);
      k = 2'($urandom_range(0, 2));
      run_op(e, k, nr_model(k) + (e ? 2 : 3), 1'($urandom));
    end

    // Reserved key length.
    start = 1'b1; encrypt = 1'b1; key_len = 2'd3;
    tick();
    start = 1'b0;
    #1;
    chk("err_pulse", DW'(err), DW'(1'b1));
    chk("err_busy", DW'(busy), '0);
    chk("err_done", DW'(done), '0);
    tick();
    chk("err_clear", DW'(err), '0);
    for (int i = 0; i < 3; i++) begin
      chk("err_idle_busy", DW'(busy), '0);
      chk("err_idle_done", DW'(done), '0);
      tick();
    end

`ifdef AES_SEQ_ABORT_EN
    run_to_round(2'd0, 3);
    abort = 1'b1;
    #1;
    chk("abort_no_done", DW'(done), '0);
    tick();
    abort = 1'b0;
    #1;
    chk("abort_ready", DW'(ready), DW'(1'b1));
    chk("abort_round", DW'(round), '0);
    chk("abort_tx", tx_data, exp_tx_last);
    for (int i = 0; i < 15; i++) begin
      chk("abort_quiet", DW'(done), '0);
      tick();
    end
    start = 1'b1; abort = 1'b1; encrypt = 1'b1; key_len = 2'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_start_idle", DW'(ready), DW'(1'b1));
    run_op(1'b1, 2'd0, 12, 1'b0);
`endif

    // Asynchronous reset in the middle of a key_len=01 operation.
    run_to_round(2'd1, 7);
    n_rst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    tick();
    chk_reset_outs("midrst_hold");
    @(negedge clk); n_rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_done", DW'(done), '0);
      chk("post_rst_ready", DW'(ready), DW'(1'b1));
      tick();
    end
    run_op(1'b0, 2'd2, 17, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
